// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Brief    : Instruction fetch unit with one outstanding memory read, a
//            circular fetch queue, branch redirect and halt on zero instruction.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
  parameter int                PC_L     = 32,
  parameter int                INST_L   = 32,
  parameter int                FQ_DEPTH = 4,
  parameter logic [PC_L-1:0]   PC_ENTRY = 32'h00000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect,
  input  logic [PC_L-1:0]               redirect_pc,
  output logic                          mem_req,
  output logic [PC_L-1:0]               mem_addr,
  input  logic                          mem_gnt,
  input  logic                          mem_rvalid,
  input  logic [INST_L-1:0]             mem_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INST_L-1:0]             out_inst,
  output logic [PC_L-1:0]               out_pc,
  output logic                          halted,
  output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count
);

  localparam int               c_PTR_W  = $clog2(FQ_DEPTH);
  localparam int               c_CNT_W  = $clog2(FQ_DEPTH + 1);
  localparam logic [PC_L-1:0]  c_PC_INC = PC_L'(4);
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FQ_DEPTH);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PC_L-1:0]      r_pc;
  logic [PC_L-1:0]      w_pc_nxt;
  logic [PC_L-1:0]      r_pc_req;
  logic [PC_L-1:0]      w_pc_req_nxt;
  logic                 r_drop;
  logic                 w_drop_nxt;

  logic [c_PTR_W-1:0]   r_wptr;
  logic [c_PTR_W-1:0]   r_rptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [INST_L-1:0]    r_q_inst [FQ_DEPTH];
  logic [PC_L-1:0]      r_q_pc   [FQ_DEPTH];

  logic                 w_full;
  logic                 w_nonempty;
  logic                 w_issue;
  logic                 w_enq;
  logic                 w_deq;
  logic [PC_L-1:0]      w_redirect_target;
  logic                 w_unused_ok;

  assign w_full            = (r_count == c_FULL);
  assign w_nonempty        = (r_count != '0);
  assign w_redirect_target = {redirect_pc[PC_L-1:2], 2'b00};
  assign w_unused_ok       = ^redirect_pc[1:0];

  // Request is masked during reset so nothing leaks out while rst is held.
  assign mem_req   = (r_state == S_FETCH) & ~w_full & ~redirect & ~rst;
  assign mem_addr  = r_pc;
  assign w_issue   = mem_req & mem_gnt;

  assign out_valid = w_nonempty & ~redirect;
  assign out_inst  = w_nonempty ? r_q_inst[r_rptr] : '0;
  assign out_pc    = w_nonempty ? r_q_pc[r_rptr]   : '0;
  assign w_deq     = out_valid & out_ready;
  assign halted    = (r_state == S_HALT);
  assign fq_count  = r_count;

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_pc_req_nxt = r_pc_req;
    w_drop_nxt   = r_drop;
    w_enq        = 1'b0;
    if (redirect) begin
      w_pc_nxt = w_redirect_target;
      // An in-flight read must still be absorbed; if it lands this very
      // cycle it is simply discarded and no drop is armed.
      if ((r_state == S_WAIT) && !mem_rvalid) begin
        w_drop_nxt  = 1'b1;
        w_state_nxt = S_WAIT;
      end else begin
        w_drop_nxt  = 1'b0;
        w_state_nxt = S_FETCH;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_issue) begin
            w_pc_req_nxt = r_pc;
            w_pc_nxt     = r_pc + c_PC_INC;
            w_state_nxt  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            if (r_drop) begin
              w_drop_nxt  = 1'b0;
              w_state_nxt = S_FETCH;
            end else if (mem_rdata == '0) begin
              w_state_nxt = S_HALT;
            end else begin
              w_enq       = 1'b1;
              w_state_nxt = S_FETCH;
            end
          end
        end
        S_HALT:  w_state_nxt = S_HALT;
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_pc     <= PC_ENTRY;
      r_pc_req <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_pc_req <= w_pc_req_nxt;
      r_drop   <= w_drop_nxt;
    end
  end

  // Pointers wrap naturally because FQ_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) r_rptr <= r_rptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_inst[r_wptr] <= mem_rdata;
      r_q_pc[r_wptr]   <= r_pc_req;
    end
  end

endmodule
`default_nettype wire
